// File: rtl/counter_updown_mod_pkg.sv
// Shared defaults and elaboration helpers for the up/down modulo counter family.
package counter_updown_mod_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MODULUS  = 256;
    localparam int DEF_PRESCALE = 1;
    localparam int DEF_SATURATE = 0;

    // A prescale of 1 still gets a 1-bit register so the sub-module needs no special case.
    function automatic int pre_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

    function automatic bit params_legal(input int width, input int modulus, input int prescale);
        return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width)) && (prescale >= 1);
    endfunction

endpackage

// File: rtl/counter_updown_mod_tick_prescaler.sv
// Enable prescaler: emits one tick per PRESCALE enabled cycles; en=0 freezes the phase.
module tick_prescaler
    import counter_updown_mod_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr_pre,
    output logic tick
);

    localparam int            PW      = pre_width(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;

    assign tick = en && (r_pre == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (clr_pre || tick) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= r_pre + 1'b1;
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// WIDTH-bit modulo-MODULUS up/down counter with prescaler, clear, clamped load,
// optional saturation, registered boundary pulses and combinational terminal count.
module counter_updown_mod
    import counter_updown_mod_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULUS  = DEF_MODULUS,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int SATURATE = DEF_SATURATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             tc
);

    generate
        if (!params_legal(WIDTH, MODULUS, PRESCALE)) begin : g_bad_params
            $error("counter_updown_mod: illegal WIDTH/MODULUS/PRESCALE combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] w_count_next;
    logic             w_ovf_next;
    logic             w_unf_next;
    logic             w_tick;
    logic             w_clr_pre;

    assign w_clr_pre = clr | load;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr_pre (w_clr_pre),
        .tick    (w_tick)
    );

    // Boundaries are compared explicitly so MODULUS below 2^WIDTH wraps correctly.
    always_comb begin
        w_count_next = r_count;
        w_ovf_next   = 1'b0;
        w_unf_next   = 1'b0;
        if (clr) begin
            w_count_next = '0;
        end else if (load) begin
            w_count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (w_tick) begin
            if (up) begin
                if (r_count == MAX_VAL) begin
                    w_ovf_next = 1'b1;
                    if (SATURATE == 0) w_count_next = '0;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end else begin
                if (r_count == '0) begin
                    w_unf_next = 1'b1;
                    if (SATURATE == 0) w_count_next = MAX_VAL;
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    assign count = r_count;
    assign ovf   = r_ovf;
    assign unf   = r_unf;
    assign tc    = (up && (r_count == MAX_VAL)) || (!up && (r_count == '0));

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: five counter configurations share stimulus; each task checks one instance.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [3:0] load_val4;

    logic [7:0] cnt_a, cnt_p, cnt_h;
    logic [3:0] cnt_d, cnt_s;
    logic       ovf_a, unf_a, tc_a;
    logic       ovf_d, unf_d, tc_d;
    logic       ovf_p, unf_p, tc_p;
    logic       ovf_s, unf_s, tc_s;
    logic       ovf_h, unf_h, tc_h;

    int total = 0;
    int bad   = 0;

    assign load_val4 = load_val[3:0];

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .SATURATE(0)) u_m256 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_a), .ovf(ovf_a), .unf(unf_a), .tc(tc_a));

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_m10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val4),
        .count(cnt_d), .ovf(ovf_d), .unf(unf_d), .tc(tc_d));

    counter_updown_mod #(.WIDTH(8), .MODULUS(256), .PRESCALE(4), .SATURATE(0)) u_pre4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_p), .ovf(ovf_p), .unf(unf_p), .tc(tc_p));

    counter_updown_mod #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(1)) u_sat16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val4),
        .count(cnt_s), .ovf(ovf_s), .unf(unf_s), .tc(tc_s));

    counter_updown_mod #(.WIDTH(8), .MODULUS(100), .PRESCALE(1), .SATURATE(0)) u_m100 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_h), .ovf(ovf_h), .unf(unf_h), .tc(tc_h));

    task automatic do_reset();
        @(posedge clk);
        #1;
        en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #99;
        total++;
        if ({cnt_a, ovf_a, unf_a} !== 10'd0) begin
            $display("FAIL reset_state: count=%0d ovf=%b unf=%b required 0/0/0", cnt_a, ovf_a, unf_a); bad++;
        end
        total++;
        if (tc_a !== 1'b1) begin
            $display("FAIL reset_tc_down: tc=%b required 1", tc_a); bad++;
        end
        up = 1'b1;
        #1;
        total++;
        if (tc_a !== 1'b0) begin
            $display("FAIL reset_tc_up: tc=%b required 0", tc_a); bad++;
        end
        $display("reset: count=%0d ovf=%b unf=%b tc=%b", cnt_a, ovf_a, unf_a, tc_a);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_c;
        for (int k = 1; k <= 257; k++) begin
            @(posedge clk);
            #1;
            exp_c = 8'(k % 256);
            $display("wrap k=%0d: count=%0d ovf=%b tc=%b", k, cnt_a, ovf_a, tc_a);
            total++;
            if (cnt_a !== exp_c || ovf_a !== (k == 256) || unf_a !== 1'b0 || tc_a !== (exp_c == 8'd255)) begin
                $display("FAIL wrap k=%0d: count=%0d ovf=%b unf=%b tc=%b required %0d/%b/0/%b",
                         k, cnt_a, ovf_a, unf_a, tc_a, exp_c, (k == 256), (exp_c == 8'd255));
                bad++;
            end
        end
    endtask

    task automatic test_modulo_down();
        logic [3:0] exp_c;
        do_reset();
        en = 1'b1; up = 1'b0;
        #1;
        total++;
        if (tc_d !== 1'b1) begin
            $display("FAIL down_tc_start: tc=%b required 1", tc_d); bad++;
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            exp_c = 4'((10 - (k % 10)) % 10);
            $display("down k=%0d: count=%0d unf=%b tc=%b", k, cnt_d, unf_d, tc_d);
            total++;
            if (cnt_d !== exp_c || unf_d !== ((k % 10) == 1) || ovf_d !== 1'b0 || tc_d !== (exp_c == 4'd0)) begin
                $display("FAIL down k=%0d: count=%0d unf=%b ovf=%b tc=%b required %0d/%b/0/%b",
                         k, cnt_d, unf_d, ovf_d, tc_d, exp_c, ((k % 10) == 1), (exp_c == 4'd0));
                bad++;
            end
        end
    endtask

    task automatic test_prescaler();
        int en_v  [15] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
        int exp_v [15] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 3};
        do_reset();
        up = 1'b1;
        for (int i = 0; i < 15; i++) begin
            en = en_v[i][0];
            @(posedge clk);
            #1;
            $display("prescale edge=%0d en=%b: count=%0d", i + 1, en, cnt_p);
            total++;
            if (cnt_p !== 8'(exp_v[i]) || ovf_p !== 1'b0 || unf_p !== 1'b0 || tc_p !== 1'b0) begin
                $display("FAIL prescale edge=%0d: count=%0d ovf=%b unf=%b tc=%b required %0d/0/0/0",
                         i + 1, cnt_p, ovf_p, unf_p, tc_p, exp_v[i]);
                bad++;
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        load_val = 8'd14; load = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (cnt_s !== 4'd14 || ovf_s !== 1'b0) begin
            $display("FAIL sat_load: count=%0d ovf=%b required 14/0", cnt_s, ovf_s); bad++;
        end
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(posedge clk);
            #1;
            $display("saturate tick=%0d: count=%0d ovf=%b tc=%b", t, cnt_s, ovf_s, tc_s);
            total++;
            if (cnt_s !== 4'd15 || ovf_s !== (t >= 2) || unf_s !== 1'b0 || tc_s !== 1'b1) begin
                $display("FAIL sat tick=%0d: count=%0d ovf=%b unf=%b tc=%b required 15/%b/0/1",
                         t, cnt_s, ovf_s, unf_s, tc_s, (t >= 2));
                bad++;
            end
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cnt_s !== 4'd15 || ovf_s !== 1'b0) begin
            $display("FAIL sat_idle: count=%0d ovf=%b required 15/0", cnt_s, ovf_s); bad++;
        end
    endtask

    task automatic test_load_priority();
        do_reset();
        load_val = 8'd200; load = 1'b1;
        @(posedge clk);
        #1;
        $display("load 200: count=%0d", cnt_h);
        total++;
        if (cnt_h !== 8'd99 || ovf_h !== 1'b0 || tc_h !== 1'b0) begin
            $display("FAIL load_clamp200: count=%0d ovf=%b tc=%b required 99/0/0", cnt_h, ovf_h, tc_h); bad++;
        end
        load_val = 8'd37;
        @(posedge clk);
        #1;
        total++;
        if (cnt_h !== 8'd37) begin
            $display("FAIL load_plain: count=%0d required 37", cnt_h); bad++;
        end
        load_val = 8'd100;
        @(posedge clk);
        #1;
        total++;
        if (cnt_h !== 8'd99) begin
            $display("FAIL load_clamp100: count=%0d required 99", cnt_h); bad++;
        end
        load_val = 8'd99; en = 1'b1; up = 1'b1;
        @(posedge clk);
        #1;
        $display("load on tick: count=%0d ovf=%b", cnt_h, ovf_h);
        total++;
        if (cnt_h !== 8'd99 || ovf_h !== 1'b0 || unf_h !== 1'b0 || tc_h !== 1'b1) begin
            $display("FAIL load_vs_tick: count=%0d ovf=%b unf=%b tc=%b required 99/0/0/1",
                     cnt_h, ovf_h, unf_h, tc_h);
            bad++;
        end
        clr = 1'b1; load_val = 8'd50;
        @(posedge clk);
        #1;
        $display("clr with load: count=%0d", cnt_h);
        total++;
        if (cnt_h !== 8'd0 || ovf_h !== 1'b0) begin
            $display("FAIL clr_vs_load: count=%0d ovf=%b required 0/0", cnt_h, ovf_h); bad++;
        end
        clr = 1'b0; load = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cnt_h !== 8'd1) begin
            $display("FAIL after_clr_step: count=%0d required 1", cnt_h); bad++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_val = 8'h37; load = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (cnt_a !== 8'h37) begin
            $display("FAIL async_preload: count=%0h required 37", cnt_a); bad++;
        end
        load = 1'b0; en = 1'b1; up = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        $display("async rst mid-cycle: count=%0h ovf=%b unf=%b", cnt_a, ovf_a, unf_a);
        total++;
        if (cnt_a !== 8'h00 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
            $display("FAIL async_clear: count=%0h ovf=%b unf=%b required 0/0/0", cnt_a, ovf_a, unf_a); bad++;
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cnt_a !== 8'd1) begin
            $display("FAIL async_resume: count=%0d required 1", cnt_a); bad++;
        end
        load_val = 8'd255; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cnt_a !== 8'd0 || ovf_a !== 1'b1) begin
            $display("FAIL async_pre_ovf: count=%0d ovf=%b required 0/1", cnt_a, ovf_a); bad++;
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (ovf_a !== 1'b0 || cnt_a !== 8'd0) begin
            $display("FAIL async_flag_clear: count=%0d ovf=%b required 0/0", cnt_a, ovf_a); bad++;
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cnt_a !== 8'd1 || ovf_a !== 1'b0) begin
            $display("FAIL async_resume2: count=%0d ovf=%b required 1/0", cnt_a, ovf_a); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_modulo_down();
        test_prescaler();
        test_saturate();
        test_load_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
